// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-port round-robin arbiter for the memory-mapped I/O bus
// One transaction in flight; read data returns to the owning port after READ_LATENCY cycles.
module io_bus_arbiter #(
  parameter int READ_LATENCY = 2
) (
  input  logic        main_clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [31:0] address_out_io,
  output logic [15:0] data_out_io,
  output logic [1:0]  control_out_io,
  input  logic [15:0] data_in_io
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ, TURNAROUND} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = port B granted last
  logic        owner_q, owner_d;            // 1 = port B owns the bus
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;

  logic        pick_b;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [15:0] sel_wdata;

  // On a tie the port not granted last wins.
  assign pick_b    = b_req && (!a_req || !last_grant_q);
  assign sel_we    = pick_b ? b_we : a_we;
  assign sel_addr  = pick_b ? b_addr : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d = pick_b;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_we ? sel_wdata : 16'h0000;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        last_grant_d = owner_q;
        if (we_q) begin
          state_d = TURNAROUND;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT_READ;
        end
      end
      WAIT_READ: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (owner_q) begin
            b_rdata_d  = data_in_io;
            b_rvalid_d = 1'b1;
          end else begin
            a_rdata_d  = data_in_io;
            a_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TURNAROUND: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 16'h0;
      cnt_q        <= 4'd0;
      a_rdata_q    <= 16'h0;
      b_rdata_q    <= 16'h0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
    end
  end

  assign control_out_io = (state_q == ISSUE) ? (we_q ? 2'b10 : 2'b01) : 2'b00;
  assign address_out_io = addr_q;
  assign data_out_io    = wdata_q;
  assign a_gnt          = (state_q == ISSUE) && !owner_q;
  assign b_gnt          = (state_q == ISSUE) && owner_q;
  assign a_rvalid       = a_rvalid_q;
  assign b_rvalid       = b_rvalid_q;
  assign a_rdata        = a_rdata_q;
  assign b_rdata        = b_rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic [15:0] din2, din1, din15;

  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata, data_out_io;
  logic [31:0] address_out_io;
  logic [1:0]  control_out_io;

  logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1;
  logic [15:0] a_rdata1, b_rdata1, dout1;
  logic [31:0] addr1;
  logic [1:0]  ctrl1;

  logic        a_gnt15, a_rvalid15, b_gnt15, b_rvalid15;
  logic [15:0] a_rdata15, b_rdata15, dout15;
  logic [31:0] addr15;
  logic [1:0]  ctrl15;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.READ_LATENCY(2)) u_dut (
    .main_clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .address_out_io(address_out_io), .data_out_io(data_out_io),
    .control_out_io(control_out_io), .data_in_io(din2)
  );

  io_bus_arbiter #(.READ_LATENCY(1)) u_dut_l1 (
    .main_clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .address_out_io(addr1), .data_out_io(dout1),
    .control_out_io(ctrl1), .data_in_io(din1)
  );

  io_bus_arbiter #(.READ_LATENCY(15)) u_dut_l15 (
    .main_clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt15), .a_rvalid(a_rvalid15), .a_rdata(a_rdata15),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt15), .b_rvalid(b_rvalid15), .b_rdata(b_rdata15),
    .address_out_io(addr15), .data_out_io(dout15),
    .control_out_io(ctrl15), .data_in_io(din15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 16'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 16'h0;
    din2 = 16'h0; din1 = 16'h0; din15 = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int gcount;
    int gcyc[4];
    int gwho[4];

    idle_inputs();
    do_reset();

    // reset state
    check("rst_ctrl", 32'(control_out_io), 32'h0);
    check("rst_addr", address_out_io, 32'h0);
    check("rst_dout", 32'(data_out_io), 32'h0);
    check("rst_gnt", 32'({a_gnt, b_gnt}), 32'h0);
    check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
    check("rst_rdata", {a_rdata, b_rdata}, 32'h0);

    // single write from A
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_1000; a_wdata = 16'hBEEF;
    tick();
    check("wr_ctrl", 32'(control_out_io), 32'h2);
    check("wr_addr", address_out_io, 32'h0000_1000);
    check("wr_dout", 32'(data_out_io), 32'hBEEF);
    check("wr_gnt", 32'({a_gnt, b_gnt}), 32'h2);
    a_req = 1'b0;
    tick();
    check("wr_ta_ctrl", 32'(control_out_io), 32'h0);
    check("wr_ta_gnt", 32'({a_gnt, b_gnt}), 32'h0);
    tick();
    check("wr_idle_ctrl", 32'(control_out_io), 32'h0);
    check("wr_dout_hold", 32'(data_out_io), 32'hBEEF);

    // single read from B, latency 2
    do_reset();
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
    tick();
    check("rd_ctrl", 32'(control_out_io), 32'h1);
    check("rd_gnt", 32'({a_gnt, b_gnt}), 32'h1);
    check("rd_addr", address_out_io, 32'h20);
    check("rd_dout", 32'(data_out_io), 32'h0);
    b_req = 1'b0;
    tick();
    check("rd_wait_ctrl", 32'(control_out_io), 32'h0);
    check("rd_wait_addr", address_out_io, 32'h20);
    tick();
    din2 = 16'h1234;
    check("rd_early_rvalid", 32'(b_rvalid), 32'h0);
    tick();
    din2 = 16'hDEAD;
    check("rd_rvalid", 32'({a_rvalid, b_rvalid}), 32'h1);
    check("rd_b_rdata", 32'(b_rdata), 32'h1234);
    check("rd_a_rdata", 32'(a_rdata), 32'h0);
    tick();
    check("rd_rvalid_pulse", 32'(b_rvalid), 32'h0);
    check("rd_b_rdata_hold", 32'(b_rdata), 32'h1234);

    // contention: both write continuously from reset
    idle_inputs();
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'hA0; a_wdata = 16'hAAAA;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'hB0; b_wdata = 16'hBBBB;
    tick();
    reset = 1'b0;
    gcount = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (a_gnt && b_gnt) check("cont_both_gnt", 32'h1, 32'h0);
      if ((a_gnt || b_gnt) && gcount < 4) begin
        gcyc[gcount] = cyc;
        gwho[gcount] = b_gnt ? 1 : 0;
        check("cont_dout", 32'(data_out_io), b_gnt ? 32'hBBBB : 32'hAAAA);
        gcount++;
      end
    end
    check("cont_count", 32'(gcount), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gcount) begin
        check("cont_who", 32'(gwho[k]), 32'(k % 2));
        check("cont_cycle", 32'(gcyc[k]), 32'(1 + 3 * k));
      end
    end

    // B requests while A's read is in progress
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h40;
    tick();
    check("busy_a_gnt", 32'(a_gnt), 32'h1);
    a_req = 1'b0;
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h50; b_wdata = 16'h5555;
    check("busy_b_wait1", 32'(b_gnt), 32'h0);
    tick();
    din2 = 16'hA5A5;
    check("busy_b_wait2", 32'(b_gnt), 32'h0);
    tick();
    check("busy_a_rvalid", 32'(a_rvalid), 32'h1);
    check("busy_a_rdata", 32'(a_rdata), 32'hA5A5);
    check("busy_b_wait3", 32'(b_gnt), 32'h0);
    check("busy_b_rdata", 32'(b_rdata), 32'h0);
    tick();
    check("busy_b_gnt", 32'({a_gnt, b_gnt}), 32'h1);
    check("busy_b_ctrl", 32'(control_out_io), 32'h2);
    check("busy_b_addr", address_out_io, 32'h50);
    b_req = 1'b0;

    // reset during WAIT_READ
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h70;
    tick();
    a_req = 1'b0;
    tick();
    tick();
    din2 = 16'h7777;
    tick();
    din2 = 16'h0;
    check("rm_prime_rdata", 32'(a_rdata), 32'h7777);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h74;
    tick();
    check("rm_issue", 32'(a_gnt), 32'h1);
    a_req = 1'b0;
    tick();
    reset = 1'b1;
    din2 = 16'h9999;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rm_no_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
      check("rm_ctrl", 32'(control_out_io), 32'h0);
    end
    check("rm_rdata", 32'(a_rdata), 32'h0);
    check("rm_addr", address_out_io, 32'h0);
    reset = 1'b0;
    din2 = 16'h0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h80; b_wdata = 16'h8080;
    tick();
    check("rm_after_gnt", 32'({a_gnt, b_gnt}), 32'h1);
    check("rm_after_ctrl", 32'(control_out_io), 32'h2);
    b_req = 1'b0;
    tick();
    check("rm_after_rvalid", 32'(a_rvalid), 32'h0);

    // latency sweep: READ_LATENCY 1 and 15 instances
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h60;
    tick();
    check("sw_gnt1", 32'(a_gnt1), 32'h1);
    check("sw_gnt15", 32'(a_gnt15), 32'h1);
    a_req = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      din1  = (k == 1)  ? 16'h1111 : 16'hEEEE;
      din15 = (k == 15) ? 16'hF0F0 : 16'hEEEE;
      check("sw_rvalid1", 32'(a_rvalid1), (k == 2) ? 32'h1 : 32'h0);
      check("sw_rvalid15", 32'(a_rvalid15), (k == 16) ? 32'h1 : 32'h0);
    end
    check("sw_rdata1", 32'(a_rdata1), 32'h1111);
    check("sw_rdata15", 32'(a_rdata15), 32'hF0F0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
